// File: rtl/tag_sort_pkg.sv
// Shared widths, FSM encoding and arbitration constants for the tag-sort storage controller.
package tag_sort_pkg;

    localparam int unsigned T_W = 4;
    localparam int unsigned I_W = 4;
    localparam int unsigned S_W = 4;
    localparam int unsigned M_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR_ISSUE = 3'd1,
        ST_WR_WAIT  = 3'd2,
        ST_RD_ISSUE = 3'd3,
        ST_RD_WAIT  = 3'd4,
        ST_RD_DONE  = 3'd5
    } state_e;

    localparam logic GRANT_WRITE = 1'b0;
    localparam logic GRANT_READ  = 1'b1;

    // Bit positions inside the arbiter request/grant vectors.
    localparam int unsigned REQ_WR = 0;
    localparam int unsigned REQ_RD = 1;

endpackage

// File: rtl/tag_rr_arb.sv
// Two-requester round-robin arbiter: combinational one-hot grant, registered last-winner.
module tag_rr_arb
    import tag_sort_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt_c,
    output logic       last_grant_q
);

    logic last_grant_d;

    always_comb begin
        gnt_c        = req;
        last_grant_d = last_grant_q;
        // On a contest the side that did not win last time takes it.
        if (req[REQ_WR] && req[REQ_RD]) begin
            gnt_c = 2'b00;
            if (last_grant_q == GRANT_READ) begin
                gnt_c[REQ_WR] = 1'b1;
            end else begin
                gnt_c[REQ_RD] = 1'b1;
            end
        end
        if (advance && gnt_c[REQ_WR]) begin
            last_grant_d = GRANT_WRITE;
        end else if (advance && gnt_c[REQ_RD]) begin
            last_grant_d = GRANT_READ;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= GRANT_READ;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/tag_storage_ctrl.sv
// Serializes enqueue/dequeue requests onto the single-port tag storage and tracks occupancy.
module tag_storage_ctrl
    import tag_sort_pkg::*;
#(
    parameter int unsigned T          = T_W,
    parameter int unsigned I          = I_W,
    parameter int unsigned S          = S_W,
    parameter int unsigned M          = M_W,
    parameter int unsigned RD_LAT     = 2,
    parameter int unsigned WR_TIMEOUT = 31
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         enq_valid,
    output logic         enq_ready,
    input  logic [M-1:0] enq_ptr,
    input  logic [T-1:0] enq_tag,
    input  logic [I-1:0] enq_pak_id,
    input  logic [S-1:0] enq_pak_addr,
    input  logic         deq_req,
    output logic         deq_valid,
    output logic [T-1:0] deq_tag,
    output logic [I-1:0] deq_pak_id,
    output logic [S-1:0] deq_addr,
    output logic         st_wr_req,
    output logic         st_rd_req,
    output logic [M-1:0] st_ipointer,
    output logic [T-1:0] st_tag,
    output logic [I-1:0] st_pak_id,
    output logic [S-1:0] st_pak_addr,
    input  logic         st_wr_done,
    input  logic [T-1:0] st_op_tag,
    input  logic [I-1:0] st_op_pak_id,
    input  logic [S-1:0] st_op_addr,
    output logic [M:0]   occupancy,
    output logic         full,
    output logic         empty,
    output logic         busy,
    output logic         err_timeout
);

    localparam int unsigned OCC_W   = M + 1;
    localparam int unsigned DEPTH   = 1 << M;
    localparam int unsigned CNT_MAX = (WR_TIMEOUT > RD_LAT) ? WR_TIMEOUT : RD_LAT;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [OCC_W-1:0]   occ_q, occ_d;
    logic               full_q, full_d, empty_q, empty_d, busy_q, busy_d;
    logic               err_q, err_d;
    logic               st_wr_req_q, st_wr_req_d, st_rd_req_q, st_rd_req_d;
    logic [M-1:0]       st_ptr_q, st_ptr_d;
    logic [T-1:0]       st_tag_q, st_tag_d;
    logic [I-1:0]       st_id_q, st_id_d;
    logic [S-1:0]       st_addr_q, st_addr_d;
    logic               deq_valid_q, deq_valid_d;
    logic [T-1:0]       deq_tag_q, deq_tag_d;
    logic [I-1:0]       deq_id_q, deq_id_d;
    logic [S-1:0]       deq_addr_q, deq_addr_d;

    logic               write_ok_c, read_ok_c, idle_c;
    logic [1:0]         gnt_c;
    logic               last_grant;

    assign idle_c     = (state_q == ST_IDLE);
    assign write_ok_c = enq_valid && !full_q;
    assign read_ok_c  = deq_req && !empty_q;

    tag_rr_arb u_arb (
        .clk          (clk),
        .rst          (rst),
        .req          ({read_ok_c, write_ok_c}),
        .advance      (idle_c && (write_ok_c || read_ok_c)),
        .gnt_c        (gnt_c),
        .last_grant_q (last_grant)
    );

    assign enq_ready = idle_c && write_ok_c && (!read_ok_c || (last_grant == GRANT_READ));

    // Next-state, counters and data latches.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        occ_d       = occ_q;
        err_d       = err_q;
        st_wr_req_d = 1'b0;
        st_rd_req_d = 1'b0;
        deq_valid_d = 1'b0;
        st_ptr_d    = st_ptr_q;
        st_tag_d    = st_tag_q;
        st_id_d     = st_id_q;
        st_addr_d   = st_addr_q;
        deq_tag_d   = deq_tag_q;
        deq_id_d    = deq_id_q;
        deq_addr_d  = deq_addr_q;

        case (state_q)
            ST_IDLE: begin
                if (gnt_c[REQ_WR]) begin
                    st_ptr_d    = enq_ptr;
                    st_tag_d    = enq_tag;
                    st_id_d     = enq_pak_id;
                    st_addr_d   = enq_pak_addr;
                    st_wr_req_d = 1'b1;
                    state_d     = ST_WR_ISSUE;
                end else if (gnt_c[REQ_RD]) begin
                    st_rd_req_d = 1'b1;
                    state_d     = ST_RD_ISSUE;
                end
            end
            ST_WR_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_WR_WAIT;
            end
            ST_WR_WAIT: begin
                // Completion takes priority over a coincident timeout.
                if (st_wr_done) begin
                    occ_d   = occ_q + OCC_W'(1);
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_W'(WR_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RD_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (cnt_q == CNT_W'(RD_LAT - 1)) begin
                    deq_tag_d   = st_op_tag;
                    deq_id_d    = st_op_pak_id;
                    deq_addr_d  = st_op_addr;
                    deq_valid_d = 1'b1;
                    state_d     = ST_RD_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RD_DONE: begin
                occ_d   = occ_q - OCC_W'(1);
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        full_d  = (occ_d == OCC_W'(DEPTH));
        empty_d = (occ_d == '0);
        busy_d  = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            occ_q       <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            st_wr_req_q <= 1'b0;
            st_rd_req_q <= 1'b0;
            st_ptr_q    <= '0;
            st_tag_q    <= '0;
            st_id_q     <= '0;
            st_addr_q   <= '0;
            deq_valid_q <= 1'b0;
            deq_tag_q   <= '0;
            deq_id_q    <= '0;
            deq_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            occ_q       <= occ_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
            st_wr_req_q <= st_wr_req_d;
            st_rd_req_q <= st_rd_req_d;
            st_ptr_q    <= st_ptr_d;
            st_tag_q    <= st_tag_d;
            st_id_q     <= st_id_d;
            st_addr_q   <= st_addr_d;
            deq_valid_q <= deq_valid_d;
            deq_tag_q   <= deq_tag_d;
            deq_id_q    <= deq_id_d;
            deq_addr_q  <= deq_addr_d;
        end
    end

    assign occupancy   = occ_q;
    assign full        = full_q;
    assign empty       = empty_q;
    assign busy        = busy_q;
    assign err_timeout = err_q;
    assign st_wr_req   = st_wr_req_q;
    assign st_rd_req   = st_rd_req_q;
    assign st_ipointer = st_ptr_q;
    assign st_tag      = st_tag_q;
    assign st_pak_id   = st_id_q;
    assign st_pak_addr = st_addr_q;
    assign deq_valid   = deq_valid_q;
    assign deq_tag     = deq_tag_q;
    assign deq_pak_id  = deq_id_q;
    assign deq_addr    = deq_addr_q;

endmodule

// File: tb/tb_tag_storage_ctrl.sv
// Directed bench for tag_storage_ctrl with a behavioural min-extracting storage model.
module tb_tag_storage_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       enq_valid, enq_ready;
    logic [3:0] enq_ptr, enq_tag, enq_pak_id, enq_pak_addr;
    logic       deq_req, deq_valid;
    logic [3:0] deq_tag, deq_pak_id, deq_addr;
    logic       st_wr_req, st_rd_req;
    logic [3:0] st_ipointer, st_tag, st_pak_id, st_pak_addr;
    logic       st_wr_done;
    logic [3:0] st_op_tag, st_op_pak_id, st_op_addr;
    logic [4:0] occupancy;
    logic       full, empty, busy, err_timeout;

    logic model_done = 1'b0;
    logic late_done  = 1'b0;
    logic withhold   = 1'b0;
    logic track_occ  = 1'b0;
    assign st_wr_done = model_done || late_done;

    tag_storage_ctrl dut (
        .clk(clk), .rst(rst),
        .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_ptr(enq_ptr),
        .enq_tag(enq_tag), .enq_pak_id(enq_pak_id), .enq_pak_addr(enq_pak_addr),
        .deq_req(deq_req), .deq_valid(deq_valid), .deq_tag(deq_tag),
        .deq_pak_id(deq_pak_id), .deq_addr(deq_addr),
        .st_wr_req(st_wr_req), .st_rd_req(st_rd_req), .st_ipointer(st_ipointer),
        .st_tag(st_tag), .st_pak_id(st_pak_id), .st_pak_addr(st_pak_addr),
        .st_wr_done(st_wr_done), .st_op_tag(st_op_tag), .st_op_pak_id(st_op_pak_id),
        .st_op_addr(st_op_addr), .occupancy(occupancy), .full(full), .empty(empty),
        .busy(busy), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Storage model and monitor, both sampling mid-cycle.
    logic [3:0] m_tag[32], m_id[32], m_addr[32];
    int         m_n = 0, wr_cnt = 0, rd_cnt = 0;
    logic [3:0] p_tag = '0, p_id = '0, p_addr = '0;
    int         n_wr = 0, n_rd = 0, n_deq = 0, n_ops = 0, n_unstable = 0;
    int         wr_cyc = 0, rd_cyc = 0, err_cyc = -1, done_cyc = 0, occ_chg_cyc = 0;
    int         op_log[64];
    logic [3:0] dq_tag[64], dq_id[64], dq_addr[64];
    int         dq_lat[64];
    int         occ_min = 99, occ_max = 0;
    logic [4:0] occ_prev = '0;
    logic [3:0] snap_tag = '0, snap_id = '0, snap_addr = '0, snap_ptr = '0;
    logic       wr_track = 1'b0;

    always @(negedge clk) begin
        model_done = 1'b0;
        st_op_tag    = p_tag ^ 4'hF;
        st_op_pak_id = p_id ^ 4'hF;
        st_op_addr   = p_addr ^ 4'hF;
        if (rst) begin
            m_n = 0; wr_cnt = 0; rd_cnt = 0;
        end else begin
            if (wr_cnt > 0) begin
                wr_cnt = wr_cnt - 1;
                if (wr_cnt == 0 && !withhold) begin
                    model_done = 1'b1;
                    done_cyc = cyc;
                    m_tag[m_n] = st_tag; m_id[m_n] = st_pak_id; m_addr[m_n] = st_pak_addr;
                    m_n = m_n + 1;
                end
            end
            if (st_wr_req) wr_cnt = 8;
            if (rd_cnt > 0) begin
                rd_cnt = rd_cnt - 1;
                if (rd_cnt == 0) begin
                    st_op_tag = p_tag; st_op_pak_id = p_id; st_op_addr = p_addr;
                end
            end
            if (st_rd_req && m_n > 0) begin
                int k;
                k = 0;
                for (int j = 1; j < m_n; j++) if (m_tag[j] < m_tag[k]) k = j;
                p_tag = m_tag[k]; p_id = m_id[k]; p_addr = m_addr[k];
                for (int j = k; j < m_n - 1; j++) begin
                    m_tag[j] = m_tag[j+1]; m_id[j] = m_id[j+1]; m_addr[j] = m_addr[j+1];
                end
                m_n = m_n - 1;
                rd_cnt = 2;
            end
        end
        // Monitor
        if (st_wr_req) begin
            n_wr = n_wr + 1; wr_cyc = cyc; op_log[n_ops] = 1; n_ops = n_ops + 1;
            snap_tag = st_tag; snap_id = st_pak_id; snap_addr = st_pak_addr; snap_ptr = st_ipointer;
            wr_track = 1'b1;
        end else if (wr_track) begin
            if (!busy) wr_track = 1'b0;
            else if (st_tag !== snap_tag || st_pak_id !== snap_id ||
                     st_pak_addr !== snap_addr || st_ipointer !== snap_ptr)
                n_unstable = n_unstable + 1;
        end
        if (st_rd_req) begin
            n_rd = n_rd + 1; rd_cyc = cyc; op_log[n_ops] = 2; n_ops = n_ops + 1;
        end
        if (deq_valid) begin
            dq_tag[n_deq] = deq_tag; dq_id[n_deq] = deq_pak_id; dq_addr[n_deq] = deq_addr;
            dq_lat[n_deq] = cyc - rd_cyc; n_deq = n_deq + 1;
        end
        if (err_timeout && err_cyc < 0) err_cyc = cyc;
        if (occupancy != occ_prev) occ_chg_cyc = cyc;
        occ_prev = occupancy;
        if (track_occ) begin
            if (int'(occupancy) < occ_min) occ_min = int'(occupancy);
            if (int'(occupancy) > occ_max) occ_max = int'(occupancy);
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            failures = failures + 1;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk); #1;
            if (!busy) begin ok = 1'b1; break; end
        end
        chk("return_idle", int'(ok), 1);
    endtask

    task automatic do_write(input logic [3:0] ptr, input logic [3:0] val);
        bit ok;
        ok = 1'b0;
        enq_ptr = ptr; enq_tag = val; enq_pak_id = val; enq_pak_addr = val;
        enq_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (enq_ready) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        chk("enq_accept", int'(ok), 1);
        @(negedge clk); #1;
        enq_valid = 1'b0;
        wait_idle();
    endtask

    initial begin
        int seen_ready, base, nrd0, ndeq0, nwr0;
        int exp_ops[4];
        rst = 1'b1; enq_valid = 1'b0; deq_req = 1'b0;
        enq_ptr = '0; enq_tag = '0; enq_pak_id = '0; enq_pak_addr = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_occupancy", int'(occupancy), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_deq_valid", int'(deq_valid), 0);
        chk("rst_st_wr_req", int'(st_wr_req), 0);
        chk("rst_err", int'(err_timeout), 0);
        chk("rst_enq_ready_idle", int'(enq_ready), 0);
        enq_valid = 1'b1; #1;
        chk("rst_enq_ready_req", int'(enq_ready), 1);
        enq_valid = 1'b0;
        @(negedge clk); rst = 1'b0;

        // Single write
        do_write(4'd0, 4'd1);
        chk("w1_wr_pulses", n_wr, 1);
        chk("w1_st_stable", n_unstable, 0);
        chk("w1_st_tag", int'(st_tag), 1);
        chk("w1_occupancy", int'(occupancy), 1);
        chk("w1_empty", int'(empty), 0);
        chk("w1_done_dly", done_cyc - wr_cyc, 8);
        chk("w1_occ_upd", occ_chg_cyc - done_cyc, 1);

        // Fill to DEPTH; the last write carries tag 16 mod 16 = 0
        for (int t = 2; t <= 16; t++) do_write(4'(t - 1), 4'(t));
        chk("fill_full", int'(full), 1);
        chk("fill_occupancy", int'(occupancy), 16);
        chk("fill_st_stable", n_unstable, 0);
        enq_ptr = 4'd3; enq_tag = 4'd9; enq_valid = 1'b1;
        seen_ready = 0;
        for (int i = 0; i < 50; i++) begin
            #1; if (enq_ready) seen_ready = 1;
            @(negedge clk);
        end
        enq_valid = 1'b0;
        chk("full_enq_ready", seen_ready, 0);
        chk("full_no_wr_req", n_wr, 16);

        // Drain with deq_req held
        deq_req = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk); #1;
            if (n_deq >= 16) break;
        end
        repeat (20) @(negedge clk);
        #1;
        deq_req = 1'b0;
        chk("drain_deq_count", n_deq, 16);
        chk("drain_rd_count", n_rd, 16);
        chk("drain_empty", int'(empty), 1);
        chk("drain_occupancy", int'(occupancy), 0);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drain_tag[%0d]", i), int'(dq_tag[i]), i);
            chk($sformatf("drain_id[%0d]", i), int'(dq_id[i]), i);
            chk($sformatf("drain_addr[%0d]", i), int'(dq_addr[i]), i);
            chk($sformatf("drain_lat[%0d]", i), dq_lat[i], 3);
        end

        // Contention: store 5,6,7,4, pop 4 so last_grant is READ, then hold both
        do_write(4'd0, 4'd5);
        do_write(4'd1, 4'd6);
        do_write(4'd2, 4'd7);
        do_write(4'd3, 4'd4);
        nrd0 = n_rd;
        deq_req = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk); #1;
            if (n_rd > nrd0) break;
        end
        deq_req = 1'b0;
        wait_idle();
        chk("pre_cont_tag", int'(dq_tag[16]), 4);
        chk("pre_cont_occ", int'(occupancy), 3);
        base = n_ops;
        track_occ = 1'b1;
        enq_ptr = 4'd5; enq_tag = 4'd8; enq_pak_id = 4'd8; enq_pak_addr = 4'd8;
        enq_valid = 1'b1; deq_req = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk); #1;
            if (n_ops >= base + 4) break;
        end
        enq_valid = 1'b0; deq_req = 1'b0;
        wait_idle();
        track_occ = 1'b0;
        exp_ops = '{1, 2, 1, 2};
        for (int i = 0; i < 4; i++) chk($sformatf("cont_grant[%0d]", i), op_log[base + i], exp_ops[i]);
        chk("cont_occ_min", occ_min, 3);
        chk("cont_occ_max", occ_max, 4);
        chk("cont_deq_tag0", int'(dq_tag[17]), 5);
        chk("cont_deq_tag1", int'(dq_tag[18]), 6);
        chk("cont_occ_final", int'(occupancy), 3);

        // Write timeout
        withhold = 1'b1;
        do_write(4'd6, 4'd3);
        chk("to_err", int'(err_timeout), 1);
        chk("to_occupancy", int'(occupancy), 3);
        chk("to_busy", int'(busy), 0);
        chk("to_latency", err_cyc - wr_cyc, 32);
        withhold = 1'b0;
        nwr0 = n_wr;
        late_done = 1'b1;
        @(negedge clk); #1;
        late_done = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("late_done_occ", int'(occupancy), 3);
        chk("late_done_busy", int'(busy), 0);
        chk("late_done_wr", n_wr, nwr0);
        do_write(4'd7, 4'd2);
        chk("sticky_err", int'(err_timeout), 1);
        chk("after_to_occ", int'(occupancy), 4);

        // Reset during RD_WAIT
        nrd0 = n_rd; ndeq0 = n_deq;
        deq_req = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk); #1;
            if (n_rd > nrd0) break;
        end
        @(negedge clk);
        rst = 1'b1; deq_req = 1'b0;
        @(negedge clk); #1;
        chk("mrst_deq_valid", int'(deq_valid), 0);
        chk("mrst_occupancy", int'(occupancy), 0);
        chk("mrst_busy", int'(busy), 0);
        chk("mrst_err", int'(err_timeout), 0);
        chk("mrst_empty", int'(empty), 1);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        chk("mrst_no_deq", n_deq, ndeq0);
        chk("mrst_no_rd", n_rd, nrd0 + 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
